// File: rtl/ilb_line_buffer_responder.sv
// ILB-side responder for the SoPU<->ILB two-transaction pixel handshake.
// Transaction I accepts the newest pixel. Transaction II returns the six pixels
// held above it in the same column. Six line buffers shift down one row per pixel.
//
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   IDLE    | rtr_I high, waiting for rts_I; frame_start honoured here only
//   RD      | column read issued to all six buffers (registered read latency)
//   UPD     | shift column down one row, load masked outputs, raise rts_II
//   PRESENT | hold outputs until rtr_II high (ack) and then low (complete)
module ilb_line_buffer_responder #(
  parameter  int IMG_WIDTH = 28,
  parameter  int DATA_W    = 8,
  localparam int COL_W     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sop_to_ilb_rts_I,
  output logic              sop_to_ilb_rtr_I,
  input  logic [DATA_W-1:0] sop_byte,
  input  logic              sop_to_ilb_rtr_II,
  output logic              sop_to_ilb_rts_II,
  output logic [DATA_W-1:0] ilb_byte_0,
  output logic [DATA_W-1:0] ilb_byte_1,
  output logic [DATA_W-1:0] ilb_byte_2,
  output logic [DATA_W-1:0] ilb_byte_3,
  output logic [DATA_W-1:0] ilb_byte_4,
  output logic [DATA_W-1:0] ilb_byte_5,
  input  logic              frame_start,
  output logic [COL_W-1:0]  col_idx,
  output logic              window_valid
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_UPD, S_PRESENT} state_e;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

  state_e            state_q, state_d;
  logic              rtr_q, rtr_d;
  logic              rts_q, rts_d;
  logic              ack_q, ack_d;
  logic              wv_q, wv_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [2:0]        rows_q, rows_d;
  logic [DATA_W-1:0] pix_q, pix_d;
  logic [DATA_W-1:0] byte_q [6];
  logic [DATA_W-1:0] byte_d [6];

  // Line-buffer storage and its registered read port; contents survive reset.
  logic [DATA_W-1:0] mem_q [6][IMG_WIDTH];
  logic [DATA_W-1:0] rd_q  [6];

  // Buffer read in RD, column shift-down write in UPD.
  always_ff @(posedge clk) begin
    if (state_q == S_RD) begin
      for (int k = 0; k < 6; k++) rd_q[k] <= mem_q[k][col_q];
    end
    if (state_q == S_UPD) begin
      mem_q[0][col_q] <= pix_q;
      for (int k = 1; k < 6; k++) mem_q[k][col_q] <= rd_q[k-1];
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rtr_q   <= 1'b0;
      rts_q   <= 1'b0;
      ack_q   <= 1'b0;
      wv_q    <= 1'b0;
      col_q   <= '0;
      rows_q  <= '0;
      pix_q   <= '0;
      for (int k = 0; k < 6; k++) byte_q[k] <= '0;
    end else begin
      state_q <= state_d;
      rtr_q   <= rtr_d;
      rts_q   <= rts_d;
      ack_q   <= ack_d;
      wv_q    <= wv_d;
      col_q   <= col_d;
      rows_q  <= rows_d;
      pix_q   <= pix_d;
      for (int k = 0; k < 6; k++) byte_q[k] <= byte_d[k];
    end
  end

  // Next-state and output decode for the two-transaction handshake.
  always_comb begin
    state_d = state_q;
    rts_d   = rts_q;
    ack_d   = ack_q;
    col_d   = col_q;
    rows_d  = rows_q;
    pix_d   = pix_q;
    for (int k = 0; k < 6; k++) byte_d[k] = byte_q[k];

    case (state_q)
      S_IDLE: begin
        // A coincident frame_start clears first, so the pixel lands in column 0.
        if (frame_start) begin
          col_d  = '0;
          rows_d = '0;
        end
        if (sop_to_ilb_rts_I && rtr_q) begin
          pix_d   = sop_byte;
          state_d = S_RD;
        end
      end
      S_RD: state_d = S_UPD;
      S_UPD: begin
        // Rows not yet filled since reset/frame_start read as zero.
        for (int k = 0; k < 6; k++) begin
          byte_d[k] = (rows_q > 3'(k)) ? rd_q[k] : '0;
        end
        rts_d   = 1'b1;
        ack_d   = 1'b0;
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (!ack_q) begin
          if (sop_to_ilb_rtr_II) ack_d = 1'b1;
        end else if (!sop_to_ilb_rtr_II) begin
          rts_d   = 1'b0;
          ack_d   = 1'b0;
          for (int k = 0; k < 6; k++) byte_d[k] = '0;
          if (col_q == LAST_COL) begin
            col_d  = '0;
            rows_d = (rows_q == 3'd6) ? 3'd6 : rows_q + 3'd1;
          end else begin
            col_d = col_q + COL_W'(1);
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rtr_d = (state_d == S_IDLE);
    wv_d  = (rows_d == 3'd6);
  end

  assign sop_to_ilb_rtr_I  = rtr_q;
  assign sop_to_ilb_rts_II = rts_q;
  assign ilb_byte_0        = byte_q[0];
  assign ilb_byte_1        = byte_q[1];
  assign ilb_byte_2        = byte_q[2];
  assign ilb_byte_3        = byte_q[3];
  assign ilb_byte_4        = byte_q[4];
  assign ilb_byte_5        = byte_q[5];
  assign col_idx           = col_q;
  assign window_valid      = wv_q;

endmodule

// File: tb/tb_ilb_line_buffer_responder.sv
// Self-checking bench for ilb_line_buffer_responder (narrow image, IMG_WIDTH=4).
module tb_ilb_line_buffer_responder;
  localparam int W  = 4;
  localparam int DW = 8;
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rts_I = 1'b0;
  logic          rtr_II = 1'b0;
  logic          frame_start = 1'b0;
  logic [DW-1:0] sop_byte = '0;
  logic          rtr_I, rts_II, window_valid;
  logic [DW-1:0] b0, b1, b2, b3, b4, b5;
  logic [CW-1:0] col_idx;
  logic [DW-1:0] dut_b [6];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per column, the pixels written there, newest first.
  int            m_col  = 0;
  int            m_rows = 0;
  logic [7:0]    hist [W][6];
  logic [7:0]    m_exp [6];
  logic [7:0]    last_b [6];
  bit            chk_en = 0;

  ilb_line_buffer_responder #(.IMG_WIDTH(W), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .sop_to_ilb_rts_I(rts_I), .sop_to_ilb_rtr_I(rtr_I), .sop_byte(sop_byte),
    .sop_to_ilb_rtr_II(rtr_II), .sop_to_ilb_rts_II(rts_II),
    .ilb_byte_0(b0), .ilb_byte_1(b1), .ilb_byte_2(b2),
    .ilb_byte_3(b3), .ilb_byte_4(b4), .ilb_byte_5(b5),
    .frame_start(frame_start), .col_idx(col_idx), .window_valid(window_valid)
  );

  always #5 clk = ~clk;

  always_comb begin
    dut_b[0] = b0; dut_b[1] = b1; dut_b[2] = b2;
    dut_b[3] = b3; dut_b[4] = b4; dut_b[5] = b5;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_accept(input logic [7:0] px, input bit fs);
    if (fs) begin m_col = 0; m_rows = 0; end
    for (int k = 0; k < 6; k++) m_exp[k] = (m_rows > k) ? hist[m_col][k] : 8'h00;
    for (int k = 5; k > 0; k--) hist[m_col][k] = hist[m_col][k-1];
    hist[m_col][0] = px;
  endtask

  task automatic m_complete();
    if (m_col == W-1) begin
      m_col = 0;
      if (m_rows < 6) m_rows++;
    end else begin
      m_col++;
    end
  endtask

  // Per-cycle comparison of column, window flag and data against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("col_idx", 32'(col_idx), 32'(m_col));
      chk("window_valid", 32'(window_valid), 32'(m_rows == 6));
      for (int k = 0; k < 6; k++)
        chk($sformatf("ilb_byte_%0d", k), 32'(dut_b[k]), rts_II ? 32'(m_exp[k]) : 32'h0);
    end
  end

  // One full pixel transaction with cycle-level handshake checks.
  task automatic do_pixel(input logic [7:0] px, input bit fs, input bit pre_hi,
                          input int hold, input bit hold_rts, input bit rst_mid);
    int waitc;
    int gap;
    waitc = 0;
    while (rtr_I !== 1'b1 && waitc < 20) begin @(posedge clk); #1; waitc++; end
    if (rtr_I !== 1'b1) begin chk("rtr_I_timeout", 32'(rtr_I), 32'h1); return; end
    rts_I = 1'b1; sop_byte = px; frame_start = fs; rtr_II = pre_hi;
    @(posedge clk); #1;
    m_accept(px, fs);
    frame_start = 1'b0;
    if (!hold_rts) begin rts_I = 1'b0; sop_byte = 8'($urandom); end
    chk("rtr_I_low", 32'(rtr_I), 32'h0);
    chk("rts_II_rd", 32'(rts_II), 32'h0);
    @(posedge clk); #1;
    chk("rts_II_upd", 32'(rts_II), 32'h0);
    @(posedge clk); #1;
    chk("rts_II_lat2", 32'(rts_II), 32'h1);
    for (int k = 0; k < 6; k++) last_b[k] = dut_b[k];
    if (rst_mid) begin
      #2 rst = 1'b1;
      #1;
      chk("rts_II_async_rst", 32'(rts_II), 32'h0);
      chk("byte0_async_rst", 32'(b0), 32'h0);
      m_col = 0; m_rows = 0;
      @(posedge clk); #1;
      rst = 1'b0; rtr_II = 1'b0; rts_I = 1'b0;
      chk("rtr_I_at_release", 32'(rtr_I), 32'h0);
      @(posedge clk); #1;
      chk("rtr_I_after_release", 32'(rtr_I), 32'h1);
      return;
    end
    if (!pre_hi) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        frame_start = ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
        chk("rts_II_wait", 32'(rts_II), 32'h1);
      end
      frame_start = 1'b0;
      rtr_II = 1'b1;
    end
    repeat (hold) begin
      @(posedge clk); #1;
      chk("rts_II_ack", 32'(rts_II), 32'h1);
      chk("rtr_I_busy", 32'(rtr_I), 32'h0);
    end
    rtr_II = 1'b0;
    @(posedge clk); #1;
    m_complete();
    chk("rts_II_done", 32'(rts_II), 32'h0);
    chk("rtr_I_back", 32'(rtr_I), 32'h1);
    rts_I = 1'b0;
  endtask

  task automatic fs_pulse();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    m_col = 0; m_rows = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int c = 0; c < W; c++) for (int k = 0; k < 6; k++) hist[c][k] = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // Reset then idle
    chk("rst_rtr_I", 32'(rtr_I), 32'h0);
    chk("rst_rts_II", 32'(rts_II), 32'h0);
    chk("rst_col", 32'(col_idx), 32'h0);
    chk("rst_wv", 32'(window_valid), 32'h0);
    chk_en = 1;
    @(posedge clk); #1;
    chk("rtr_I_one_cycle", 32'(rtr_I), 32'h1);

    // First pixel
    do_pixel(8'hA5, 0, 0, 1, 0, 0);
    for (int k = 0; k < 6; k++) chk("first_px_byte", 32'(last_b[k]), 32'h0);
    chk("first_px_col", 32'(col_idx), 32'h1);

    // Row stream r*16+c, restarting the frame on the first pixel
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == 5 && c == W-1) chk("wv_before_row6", 32'(window_valid), 32'h0);
        if (r == 6 && c == 0)   chk("wv_row6", 32'(window_valid), 32'h1);
        do_pixel(8'(r*16 + c), (r == 0 && c == 0), 1'($urandom_range(0, 1)),
                 $urandom_range(1, 2), 0, 0);
        if (r == 7 && c == 2) begin
          chk("r7c2_byte0", 32'(last_b[0]), 32'h62);
          chk("r7c2_byte1", 32'(last_b[1]), 32'h52);
          chk("r7c2_byte5", 32'(last_b[5]), 32'h12);
        end
      end
    end

    // rtr_II high before rts_II and held 2 cycles: single advance
    c0 = int'(col_idx);
    do_pixel(8'h3C, 0, 1, 2, 0, 0);
    chk("pre_hi_single_adv", 32'(col_idx), 32'((c0 + 1) % W));

    // rts_I held through the transaction: one pixel only
    c0 = int'(col_idx);
    do_pixel(8'h77, 0, 0, 1, 1, 0);
    chk("held_rts_single_adv", 32'(col_idx), 32'((c0 + 1) % W));
    @(posedge clk); #1;
    chk("held_rts_no_extra", 32'(rts_II), 32'h0);

    // frame_start mid-row
    do_pixel(8'h10, 0, 0, 1, 0, 0);
    fs_pulse();
    chk("fs_col", 32'(col_idx), 32'h0);
    chk("fs_wv", 32'(window_valid), 32'h0);

    // Fill fully then reset in PRESENT; next pixel must be all zero
    for (int i = 0; i < 7*W; i++) do_pixel(8'($urandom), 0, 0, 1, 0, 0);
    chk("full_wv", 32'(window_valid), 32'h1);
    do_pixel(8'h99, 0, 0, 1, 0, 1);
    do_pixel(8'h11, 0, 0, 1, 0, 0);
    for (int k = 0; k < 6; k++) chk("post_rst_byte", 32'(last_b[k]), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 15) == 0) fs_pulse();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      do_pixel(8'($urandom), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
               $urandom_range(1, 3), ($urandom_range(0, 4) == 0), 0);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
